// File: rtl/xadc_drp_responder.sv
// DRP slave model of the XADC: config regs 0x40-0x42, result reg 0x16 and a
// periodic conversion engine with optional hardware averaging.
module xadc_drp_responder #(
  parameter int          DRDY_LAT    = 4,
  parameter int          CONV_CYCLES = 26,
  parameter logic [15:0] INIT_40     = 16'h0016,
  parameter logic [15:0] INIT_41     = 16'h3000,
  parameter logic [15:0] INIT_42     = 16'h6400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  daddr,
  input  logic        den,
  input  logic        dwe,
  input  logic [15:0] di,
  output logic [15:0] do_drp,
  output logic        drdy,
  input  logic [11:0] sample_in,
  output logic        eoc,
  output logic        busy,
  output logic [4:0]  channel,
  output logic        ovr
);

  localparam int CW = $clog2(CONV_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_RECOVER} drp_state_t;

  drp_state_t    state, state_nxt;
  logic [3:0]    lat_cnt;
  logic [6:0]    a_q;
  logic          we_q;
  logic [15:0]   di_q;
  logic          accept, fire, ovr_nxt;
  logic [15:0]   rd_data;

  logic [15:0]   reg40, reg41, reg42, reg16;
  logic          run;
  logic [CW-1:0] conv_cnt;
  logic          conv_last;
  logic [19:0]   acc, sum;
  logic [7:0]    avg_cnt, avg_last;
  logic [11:0]   avg_res;
  logic          acc_en;

  assign channel   = reg40[4:0];
  assign conv_last = (conv_cnt == CW'(CONV_CYCLES - 1));
  assign eoc       = run & conv_last;
  assign busy      = run & ~conv_last;
  assign acc_en    = eoc & (reg40[4:0] == 5'h16);
  assign sum       = acc + 20'(sample_in);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fire      = 1'b0;
    ovr_nxt   = 1'b0;
    case (state)
      S_IDLE: if (den) begin
        accept    = 1'b1;
        state_nxt = S_PEND;
      end
      S_PEND: begin
        ovr_nxt = den;
        if (lat_cnt == 4'd0) begin
          fire      = 1'b1;
          state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = 16'h0000;
    case (a_q)
      7'h40:   rd_data = reg40;
      7'h41:   rd_data = reg41;
      7'h42:   rd_data = reg42;
      7'h16:   rd_data = reg16;
      default: rd_data = 16'h0000;
    endcase
  end

  // Average length N-1 and the >>k result for the selected mode
  always_comb begin
    avg_last = 8'd15;
    avg_res  = sum[15:4];
    case (reg40[13:12])
      2'b10: begin avg_last = 8'd63;  avg_res = sum[17:6]; end
      2'b11: begin avg_last = 8'd255; avg_res = sum[19:8]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      lat_cnt  <= 4'd0;
      a_q      <= 7'd0;
      we_q     <= 1'b0;
      di_q     <= 16'h0000;
      do_drp   <= 16'h0000;
      drdy     <= 1'b0;
      ovr      <= 1'b0;
      reg40    <= INIT_40;
      reg41    <= INIT_41;
      reg42    <= INIT_42;
      reg16    <= 16'h0000;
      run      <= 1'b0;
      conv_cnt <= '0;
      acc      <= 20'd0;
      avg_cnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      drdy  <= fire;
      ovr   <= ovr_nxt;
      if (accept) begin
        a_q     <= daddr;
        we_q    <= dwe;
        di_q    <= di;
        lat_cnt <= 4'(DRDY_LAT);
      end else if (state == S_PEND && !fire) begin
        lat_cnt <= lat_cnt - 4'd1;
      end

      // counter holds at 0 for the first cycle after reset release
      run <= 1'b1;
      if (run) conv_cnt <= conv_last ? '0 : conv_cnt + CW'(1);

      if (acc_en) begin
        if (reg40[13:12] == 2'b00) begin
          reg16 <= {sample_in, 4'h0};
        end else if (avg_cnt == avg_last) begin
          reg16   <= {avg_res, 4'h0};
          acc     <= 20'd0;
          avg_cnt <= 8'd0;
        end else begin
          acc     <= sum;
          avg_cnt <= avg_cnt + 8'd1;
        end
      end

      // placed after the eoc update so a same-edge 0x40 write wins the clear
      if (fire) begin
        if (we_q) begin
          case (a_q)
            7'h40: begin
              reg40   <= di_q;
              acc     <= 20'd0;
              avg_cnt <= 8'd0;
            end
            7'h41:   reg41 <= di_q;
            7'h42:   reg42 <= di_q;
            default: ;
          endcase
        end else begin
          do_drp <= rd_data;
        end
      end
    end
  end

endmodule
